// File: rtl/core_inst_sequencer.sv
// Issue-side sequencer for the core instruction interface: one start pulse runs a
// full layer pass (host fill, kernel load, execute, OFIFO drain) and emits inst/D_xmem.
module core_inst_sequencer #(
   parameter int AW         = 11,
   parameter int DW         = 32,
   parameter int IW         = 34,
   parameter int DRAIN_WAIT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] cfg_fill_len,
   input  logic [AW-1:0] cfg_kernel_len,
   input  logic [AW-1:0] cfg_act_len,
   input  logic [AW-1:0] cfg_out_len,
   input  logic [DW-1:0] host_data,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          ofifo_valid,
   output logic [IW-1:0] inst,
   output logic [DW-1:0] D_xmem,
   output logic          busy,
   output logic          done,
   output logic          timeout
);

   localparam int WW = $clog2(DRAIN_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'(DRAIN_WAIT);
   localparam logic [WW-1:0] WAIT_ONE   = {{(WW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] CNT_ZERO   = {AW{1'b0}};
   localparam logic [AW-1:0] CNT_ONE    = {{(AW-1){1'b0}}, 1'b1};

   // Low instruction bits: [6] ofifo rd, [5] in-SRAM wr, [4] in-SRAM rd,
   // [3] acc rd, [2] acc wr, [1] execute, [0] kernel load.
   localparam logic [6:0] OP_NONE  = 7'h00;
   localparam logic [6:0] OP_WR    = 7'h20;
   localparam logic [6:0] OP_LOAD  = 7'h11;
   localparam logic [6:0] OP_EXEC  = 7'h12;
   localparam logic [6:0] OP_DRAIN = 7'h44;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_GAP   = 3'd3,
      ST_EXEC  = 3'd4,
      ST_DRAIN = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   state_t        state_r;
   logic [6:0]    op_r;
   logic [DW-1:0] d_xmem_r;
   logic          host_ready_r;
   logic          busy_r;
   logic          done_r;
   logic          timeout_r;
   logic [AW-1:0] fill_cnt_r;
   logic [AW-1:0] kern_cnt_r;
   logic [AW-1:0] act_cnt_r;
   logic [AW-1:0] out_cnt_r;
   logic [WW-1:0] wait_r;

   logic          hs_s;
   logic [WW-1:0] wait_nxt_s;

   // First phase with a non-zero count; zero-length phases cascade straight through.
   function automatic state_t first_phase(input logic [AW-1:0] f, input logic [AW-1:0] k,
                                          input logic [AW-1:0] a, input logic [AW-1:0] o);
      state_t nxt;
      if (f != CNT_ZERO) begin
         nxt = ST_FILL;
      end else if (k != CNT_ZERO) begin
         nxt = ST_LOAD;
      end else if (a != CNT_ZERO) begin
         nxt = ST_EXEC;
      end else if (o != CNT_ZERO) begin
         nxt = ST_DRAIN;
      end else begin
         nxt = ST_DONE;
      end
      return nxt;
   endfunction

   // Counters saturate at zero rather than wrapping.
   function automatic logic [AW-1:0] dec_sat(input logic [AW-1:0] x);
      return (x == CNT_ZERO) ? CNT_ZERO : (x - CNT_ONE);
   endfunction

   // Host handshake and the drain idle counter's next value.
   always_comb begin
      hs_s       = host_valid & host_ready_r;
      wait_nxt_s = wait_r + WAIT_ONE;
   end

   // Pass sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         op_r         <= OP_NONE;
         d_xmem_r     <= {DW{1'b0}};
         host_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         timeout_r    <= 1'b0;
         fill_cnt_r   <= CNT_ZERO;
         kern_cnt_r   <= CNT_ZERO;
         act_cnt_r    <= CNT_ZERO;
         out_cnt_r    <= CNT_ZERO;
         wait_r       <= {WW{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               op_r <= OP_NONE;
               if (start) begin
                  fill_cnt_r   <= cfg_fill_len;
                  kern_cnt_r   <= cfg_kernel_len;
                  act_cnt_r    <= cfg_act_len;
                  out_cnt_r    <= cfg_out_len;
                  wait_r       <= {WW{1'b0}};
                  timeout_r    <= 1'b0;
                  busy_r       <= 1'b1;
                  host_ready_r <= (cfg_fill_len != CNT_ZERO);
                  state_r      <= first_phase(cfg_fill_len, cfg_kernel_len, cfg_act_len, cfg_out_len);
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_FILL: begin
               if (hs_s) begin
                  op_r       <= OP_WR;
                  d_xmem_r   <= host_data;
                  fill_cnt_r <= dec_sat(fill_cnt_r);
                  // Ready falls together with the last write appearing on inst.
                  if (fill_cnt_r <= CNT_ONE) begin
                     host_ready_r <= 1'b0;
                     state_r      <= first_phase(CNT_ZERO, kern_cnt_r, act_cnt_r, out_cnt_r);
                  end else begin
                     state_r <= ST_FILL;
                  end
               end else begin
                  op_r    <= OP_NONE;
                  state_r <= ST_FILL;
               end
            end
            ST_LOAD: begin
               op_r       <= OP_LOAD;
               kern_cnt_r <= dec_sat(kern_cnt_r);
               if (kern_cnt_r <= CNT_ONE) begin
                  state_r <= ST_GAP;
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_GAP: begin
               op_r    <= OP_NONE;
               state_r <= first_phase(CNT_ZERO, CNT_ZERO, act_cnt_r, out_cnt_r);
            end
            ST_EXEC: begin
               op_r      <= OP_EXEC;
               act_cnt_r <= dec_sat(act_cnt_r);
               if (act_cnt_r <= CNT_ONE) begin
                  state_r <= first_phase(CNT_ZERO, CNT_ZERO, CNT_ZERO, out_cnt_r);
               end else begin
                  state_r <= ST_EXEC;
               end
            end
            ST_DRAIN: begin
               if (ofifo_valid && (out_cnt_r != CNT_ZERO)) begin
                  op_r      <= OP_DRAIN;
                  out_cnt_r <= dec_sat(out_cnt_r);
                  wait_r    <= {WW{1'b0}};
                  if (out_cnt_r == CNT_ONE) begin
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else if (!ofifo_valid) begin
                  op_r   <= OP_NONE;
                  wait_r <= wait_nxt_s;
                  if (wait_nxt_s >= WAIT_LIMIT) begin
                     timeout_r <= 1'b1;
                     state_r   <= ST_DONE;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else begin
                  op_r    <= OP_NONE;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               op_r         <= OP_NONE;
               done_r       <= 1'b1;
               busy_r       <= 1'b0;
               host_ready_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
            default: begin
               op_r         <= OP_NONE;
               busy_r       <= 1'b0;
               host_ready_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign inst       = {{(IW-7){1'b0}}, op_r};
   assign D_xmem     = d_xmem_r;
   assign host_ready = host_ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign timeout    = timeout_r;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: captures the inst stream per cycle and
// compares it with hand-built expected sequences.
module tb_core_inst_sequencer;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int IW = 34;
   localparam int DRAIN_WAIT = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] cfg_fill_len, cfg_kernel_len, cfg_act_len, cfg_out_len;
   logic [DW-1:0] host_data;
   logic          host_valid;
   logic          host_ready;
   logic          ofifo_valid;
   logic [IW-1:0] inst;
   logic [DW-1:0] D_xmem;
   logic          busy, done, timeout;

   core_inst_sequencer #(.AW(AW), .DW(DW), .IW(IW), .DRAIN_WAIT(DRAIN_WAIT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_fill_len(cfg_fill_len), .cfg_kernel_len(cfg_kernel_len),
      .cfg_act_len(cfg_act_len), .cfg_out_len(cfg_out_len),
      .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
      .ofifo_valid(ofifo_valid), .inst(inst), .D_xmem(D_xmem),
      .busy(busy), .done(done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]    trace[$];
   logic [6:0]    exp_tr[$];
   logic [DW-1:0] words[8];
   int done_cnt, d_err, wr_err, n_wr, done_idx;
   logic tmo_first, tmo_at_done, busy_at_done;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_run(input logic [6:0] v, input int n);
      for (int i = 0; i < n; i++) exp_tr.push_back(v);
   endtask

   function automatic int first_diff();
      int n;
      n = (trace.size() < exp_tr.size()) ? trace.size() : exp_tr.size();
      for (int i = 0; i < n; i++) if (trace[i] !== exp_tr[i]) return i;
      if (trace.size() != exp_tr.size()) return n;
      return -1;
   endfunction

   function automatic int count_op(input logic [6:0] v);
      int c = 0;
      foreach (trace[i]) if (trace[i] == v) c++;
      return c;
   endfunction

   // One pass: start, then per negedge sample outputs and drive next-cycle inputs.
   task automatic run_pass(input int f, input int k, input int a, input int o, input bit toggle,
                           input int ofifo_pulses, input int restart_cyc, input int tag);
      int  hs_idx = 0;
      int  wr_idx = 0;
      bit  pend_wr = 1'b0;
      bit  seen = 1'b0;
      int  post = 0;
      trace.delete();
      done_cnt = 0; d_err = 0; wr_err = 0; n_wr = 0; done_idx = -1;
      tmo_first = 1'bx; tmo_at_done = 1'bx; busy_at_done = 1'bx;
      for (int i = 0; i < 8; i++) words[i] = {8'(8'hC0 + tag), 24'(i * 37 + 1)};
      @(negedge clk);
      cfg_fill_len = AW'(f); cfg_kernel_len = AW'(k); cfg_act_len = AW'(a); cfg_out_len = AW'(o);
      start = 1'b1; host_valid = 1'b0; ofifo_valid = 1'b0; host_data = words[0];
      @(negedge clk);
      start = 1'b0;
      cfg_fill_len = 11'd7; cfg_kernel_len = 11'd7; cfg_act_len = 11'd7; cfg_out_len = 11'd7;
      for (int cyc = 0; cyc < 300 && post < 4; cyc++) begin
         if (!seen) begin
            trace.push_back(inst[6:0]);
            if (cyc == 0) tmo_first = timeout;
            if (inst[5] !== pend_wr) wr_err++;
            if (inst[5] === 1'b1) begin
               if (wr_idx > 7 || D_xmem !== words[wr_idx]) d_err++;
               wr_idx++;
               n_wr++;
            end
         end else begin
            post++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (!seen) begin
               done_idx = cyc; tmo_at_done = timeout; busy_at_done = busy;
            end
            seen = 1'b1;
         end
         start      = (cyc == restart_cyc);
         host_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         host_data  = words[(hs_idx < 8) ? hs_idx : 7];
         pend_wr    = host_valid && (host_ready === 1'b1);
         if (pend_wr) hs_idx++;
         ofifo_valid = (ofifo_pulses < 0) ? 1'b1 : ((cyc < 2 * ofifo_pulses) && (cyc % 2 == 0));
         @(negedge clk);
      end
      host_valid = 1'b0; ofifo_valid = 1'b0; start = 1'b0;
      check_val($sformatf("done_seen_%0d", tag), 64'(seen), 64'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; host_valid = 1'b0; ofifo_valid = 1'b0; host_data = 32'h0;
      cfg_fill_len = 11'd0; cfg_kernel_len = 11'd0; cfg_act_len = 11'd0; cfg_out_len = 11'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_val("rst_inst", 64'(inst), 64'h0);
      check_val("rst_dxmem", 64'(D_xmem), 64'h0);
      check_val("rst_ready", 64'(host_ready), 64'h0);
      check_val("rst_busy", 64'(busy), 64'h0);
      check_val("rst_done", 64'(done), 64'h0);
      check_val("rst_timeout", 64'(timeout), 64'h0);

      // Reset in the middle of a fill
      cfg_fill_len = 11'd4; cfg_kernel_len = 11'd2; cfg_act_len = 11'd2; cfg_out_len = 11'd2;
      start = 1'b1; host_valid = 1'b1; host_data = 32'h1111_2222;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("mid_fill_wr", 64'(inst[6:0]), 64'h20);
      check_val("mid_fill_busy", 64'(busy), 64'h1);
      reset = 1'b1; host_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      check_val("mrst_inst", 64'(inst), 64'h0);
      check_val("mrst_ready", 64'(host_ready), 64'h0);
      check_val("mrst_busy", 64'(busy), 64'h0);
      @(negedge clk);
      check_val("mrst_idle_inst", 64'(inst), 64'h0);

      // Full pass without stalls
      exp_tr.delete();
      push_run(7'h00, 1); push_run(7'h20, 3); push_run(7'h11, 8); push_run(7'h00, 1);
      push_run(7'h12, 5); push_run(7'h44, 4); push_run(7'h00, 1);
      run_pass(3, 8, 5, 4, 1'b0, -1, -1, 1);
      check_val("full_trace_diff", 64'(first_diff()), 64'(-1));
      check_val("full_trace_len", 64'(trace.size()), 64'd23);
      check_val("full_writes", 64'(n_wr), 64'd3);
      check_val("full_dxmem", 64'(d_err), 64'd0);
      check_val("full_done_cnt", 64'(done_cnt), 64'd1);
      check_val("full_busy_at_done", 64'(busy_at_done), 64'd0);

      // Host backpressure: valid toggling
      exp_tr.delete();
      push_run(7'h00, 1);
      for (int i = 0; i < 3; i++) begin push_run(7'h20, 1); push_run(7'h00, 1); end
      push_run(7'h20, 1); push_run(7'h11, 1); push_run(7'h00, 1);
      push_run(7'h12, 1); push_run(7'h44, 1); push_run(7'h00, 1);
      run_pass(4, 1, 1, 1, 1'b1, -1, -1, 2);
      check_val("bp_trace_diff", 64'(first_diff()), 64'(-1));
      check_val("bp_writes", 64'(n_wr), 64'd4);
      check_val("bp_dxmem", 64'(d_err), 64'd0);
      check_val("bp_wr_timing", 64'(wr_err), 64'd0);

      // Drain stalls into timeout
      run_pass(0, 0, 0, 3, 1'b0, 2, -1, 3);
      check_val("tmo_reads", 64'(count_op(7'h44)), 64'd2);
      check_val("tmo_flag", 64'(tmo_at_done), 64'd1);
      check_val("tmo_done_idx", 64'(done_idx), 64'(3 + DRAIN_WAIT + 1));
      check_val("tmo_done_cnt", 64'(done_cnt), 64'd1);
      check_val("tmo_sticky", 64'(timeout), 64'd1);

      // Zero-length skips: straight into execute; next start clears timeout
      exp_tr.delete();
      push_run(7'h00, 1); push_run(7'h12, 2); push_run(7'h00, 1);
      run_pass(0, 0, 2, 0, 1'b0, -1, -1, 4);
      check_val("skip_tmo_clear", 64'(tmo_first), 64'd0);
      check_val("skip_trace_diff", 64'(first_diff()), 64'(-1));
      check_val("skip_done_idx", 64'(done_idx), 64'd3);

      run_pass(0, 0, 0, 0, 1'b0, -1, -1, 5);
      check_val("zero_done_idx", 64'(done_idx), 64'd1);
      check_val("zero_no_ops", 64'(count_op(7'h00)), 64'd2);

      // Second start during execute is ignored
      exp_tr.delete();
      push_run(7'h00, 1); push_run(7'h20, 3); push_run(7'h11, 8); push_run(7'h00, 1);
      push_run(7'h12, 5); push_run(7'h44, 4); push_run(7'h00, 1);
      run_pass(3, 8, 5, 4, 1'b0, -1, 14, 6);
      check_val("ign_trace_diff", 64'(first_diff()), 64'(-1));
      check_val("ign_done_cnt", 64'(done_cnt), 64'd1);
      check_val("ign_idle_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
- Issue side of the core instruction interface: generates the 34-bit inst word and D_xmem data stream that the core's address generator and corelet consume.
- Runs one layer pass from a single start pulse: host data fill of the input SRAM, kernel load, execute, then OFIFO drain into the accumulation SRAM.
- Sits between the host/testbench DMA stream and the core top.

Parameters:
- AW, 11, SRAM address/count width; matches core SRAM depth.
- DW, 32, D_xmem / host data width.
- IW, 34, instruction word width.
- DRAIN_WAIT, 64, maximum cycles to wait for ofifo_valid before flagging timeout.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; accepted only in IDLE
- cfg_fill_len  input  AW  number of host words written to input SRAM
- cfg_kernel_len  input  AW  number of kernel-load cycles
- cfg_act_len  input  AW  number of execute cycles
- cfg_out_len  input  AW  number of OFIFO words to drain
- host_data  input  DW  fill data
- host_valid  input  1  host_data valid
- host_ready  output  1  sequencer accepts host_data this cycle
- ofifo_valid  input  1  from core: OFIFO has output data
- inst  output  IW  instruction word to core
- D_xmem  output  DW  write data to core input SRAM
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on pass completion
- timeout  output  1  sticky; set on drain timeout, cleared by reset or start

Behaviour:
- Reset (synchronous): state=IDLE; inst=0, D_xmem=0, host_ready=0, busy=0, done=0, timeout=0, all counters 0.
- inst encoding: [6] OFIFO read, [5] input SRAM write, [4] input SRAM read, [3] acc SRAM read, [2] acc SRAM write, [1] execute, [0] kernel load. Bits [33:7] are driven 0. All outputs are registered.
- Config inputs are sampled into internal registers on an accepted start. Later changes to the inputs have no effect until the next start.
- States: IDLE -> FILL -> LOAD -> EXEC -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, latch config, clear timeout, go to FILL. If a count is 0, that phase is skipped on the same transition; cascade skips are allowed, so all counts 0 goes straight to DONE.
- FILL:
  - host_ready=1 while the remaining count is >0.
  - Handshake is host_valid & host_ready. On a handshake, the next cycle drives inst[5]=1 and D_xmem=host_data, and the count decrements.
  - With no handshake, inst[5]=0 and D_xmem holds its last value.
  - After the last handshake, host_ready drops in the same cycle the last write is issued. Go to LOAD.
- LOAD: inst[4]=1 and inst[0]=1 for exactly cfg_kernel_len consecutive cycles, then one gap cycle with inst=0, then EXEC.
- EXEC: inst[4]=1 and inst[1]=1 for exactly cfg_act_len consecutive cycles, then DRAIN.
- DRAIN:
  - Each cycle with ofifo_valid=1 and remaining>0 issues inst[6]=1 and inst[2]=1 on the next cycle, and the count decrements.
  - A wait counter resets on every issued read. It increments while ofifo_valid=0. When it reaches DRAIN_WAIT: set timeout=1 and go to DONE.
  - When the remaining count reaches 0, go to DONE.
- DONE: done=1 for one cycle, inst=0, then IDLE. busy deasserts in the cycle done is high.
- start while busy: ignored, no state change.
- Counters never wrap. The decrement is gated at 0.

Test Plan:
- Reset mid-FILL:
  - Stimulus: start with fill=4; after 2 handshakes assert reset for 1 cycle.
  - Response: next cycle inst=0, host_ready=0, busy=0, state IDLE; a later start works normally.
- Full pass, no stalls:
  - Stimulus: fill=3, kernel=8, act=5, out=4; host_valid held high; ofifo_valid high from EXEC end.
  - Response: exactly 3 inst[5] pulses carrying the host words in order; 8 cycles of inst=0x11; 1 cycle of inst=0; 5 cycles of inst=0x12; 4 cycles of inst=0x44; then done for 1 cycle.
- Host backpressure:
  - Stimulus: fill=4 with host_valid toggling 1,0,1,0,...
  - Response: 4 writes total, D_xmem matches each accepted word, no write in the gap cycles.
- Drain stalls and timeout:
  - Stimulus: out=3 with ofifo_valid pulsed 2 times, then held low DRAIN_WAIT cycles.
  - Response: 2 inst[6]/inst[2] pulses, then timeout=1 and done pulse; the next start clears timeout.
- Zero-length skips:
  - Stimulus: fill=0, kernel=0, act=2, out=0.
  - Response: start -> EXEC directly, 2 execute cycles, then done. Separately, all counts 0 -> done 2 cycles after start.
- Start ignored while busy:
  - Stimulus: second start pulse during EXEC.
  - Response: cycle counts unchanged; exactly one done pulse.
